// File: rtl/tsc_isa_pkg.sv
// =============================================================================
// Module   : tsc_isa_pkg
// Brief    : TSC ISA opcodes, field positions, result kinds and issue FSM states.
// Revision : 1.0
// =============================================================================
`default_nettype none

package tsc_isa_pkg;

    localparam logic [3:0] c_op_bne   = 4'd0;
    localparam logic [3:0] c_op_beq   = 4'd1;
    localparam logic [3:0] c_op_bgz   = 4'd2;
    localparam logic [3:0] c_op_blz   = 4'd3;
    localparam logic [3:0] c_op_adi   = 4'd4;
    localparam logic [3:0] c_op_ori   = 4'd5;
    localparam logic [3:0] c_op_lhi   = 4'd6;
    localparam logic [3:0] c_op_lwd   = 4'd7;
    localparam logic [3:0] c_op_swd   = 4'd8;
    localparam logic [3:0] c_op_jmp   = 4'd9;
    localparam logic [3:0] c_op_jal   = 4'd10;
    localparam logic [3:0] c_op_rtype = 4'd15;

    // R-type functs 0..7 are ALU ops that write back; 25/26 are JPR/JRL
    localparam logic [5:0] c_funct_wb_limit = 6'd8;
    localparam logic [5:0] c_funct_jpr      = 6'd25;
    localparam logic [5:0] c_funct_jrl      = 6'd26;

    localparam int c_op_msb    = 15;
    localparam int c_op_lsb    = 12;
    localparam int c_rs_msb    = 11;
    localparam int c_rs_lsb    = 10;
    localparam int c_rt_msb    = 9;
    localparam int c_rt_lsb    = 8;
    localparam int c_rd_msb    = 7;
    localparam int c_rd_lsb    = 6;
    localparam int c_funct_msb = 5;
    localparam int c_imm8_msb  = 7;
    localparam int c_tgt_msb   = 11;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_WB     = 3'd1,
        KIND_MEM    = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JUMP   = 3'd4
    } result_kind_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_ARM     = 3'd2,
        S_FIRE    = 3'd3,
        S_CAPTURE = 3'd4
    } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_operand_issue_imm_extend.sv
// =============================================================================
// Module   : imm_extend
// Brief    : Opcode-driven sign/zero extension of imm8 and zero extension of target12.
// Revision : 1.0
// =============================================================================
`default_nettype none

module imm_extend
    import tsc_isa_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] imm_value
);

    logic [3:0] w_op;

    assign w_op = instruction[c_op_msb:c_op_lsb];

    always_comb begin
        imm_value = '0;
        case (w_op)
            c_op_adi, c_op_lwd, c_op_swd:
                imm_value = {{(WORD_W-8){instruction[c_imm8_msb]}}, instruction[c_imm8_msb:0]};
            c_op_ori, c_op_lhi:
                imm_value = {{(WORD_W-8){1'b0}}, instruction[c_imm8_msb:0]};
            c_op_jmp, c_op_jal:
                imm_value = {{(WORD_W-12){1'b0}}, instruction[c_tgt_msb:0]};
            default:
                imm_value = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_operand_issue.sv
// =============================================================================
// Module   : alu_operand_issue
// Brief    : Reads operands for one instruction, pulses input_ready to the ALU, tags the result.
// Revision : 1.0
// =============================================================================
`default_nettype none

module alu_operand_issue
    import tsc_isa_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int RADDR_W    = 2,
    parameter int ARM_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [WORD_W-1:0]  instruction,
    output logic [RADDR_W-1:0] rf_addr1,
    output logic [RADDR_W-1:0] rf_addr2,
    input  logic [WORD_W-1:0]  rf_data1,
    input  logic [WORD_W-1:0]  rf_data2,
    output logic [WORD_W-1:0]  alu_input_1,
    output logic [WORD_W-1:0]  alu_input_2,
    output logic [WORD_W-1:0]  alu_instr,
    output logic               input_ready,
    input  logic [WORD_W-1:0]  alu_output,
    input  logic               branch_bit,
    output logic               result_valid,
    output logic [2:0]         result_kind,
    output logic [WORD_W-1:0]  result_data,
    output logic [RADDR_W-1:0] result_dest,
    output logic               result_taken
);

    localparam int c_cnt_w = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    issue_state_t        r_state;
    logic [c_cnt_w-1:0]  r_arm_cnt;
    logic [WORD_W-1:0]   r_instr;
    logic                r_instr_ready;
    logic [RADDR_W-1:0]  r_rf_addr1;
    logic [RADDR_W-1:0]  r_rf_addr2;
    logic [WORD_W-1:0]   r_alu_input_1;
    logic [WORD_W-1:0]   r_alu_input_2;
    logic [WORD_W-1:0]   r_alu_instr;
    logic                r_input_ready;
    logic                r_result_valid;
    result_kind_t        r_result_kind;
    logic [WORD_W-1:0]   r_result_data;
    logic [RADDR_W-1:0]  r_result_dest;
    logic                r_result_taken;

    logic                w_accept;
    logic [3:0]          w_op;
    logic [5:0]          w_funct;
    logic [WORD_W-1:0]   w_imm;
    logic [WORD_W-1:0]   w_in1;
    logic [WORD_W-1:0]   w_in2;
    result_kind_t        w_kind;
    logic [RADDR_W-1:0]  w_dest;

    assign w_accept = instr_valid & r_instr_ready;
    assign w_op     = r_instr[c_op_msb:c_op_lsb];
    assign w_funct  = r_instr[c_funct_msb:0];

    imm_extend #(
        .WORD_W      (WORD_W)
    ) u_imm_extend (
        .instruction (r_instr),
        .imm_value   (w_imm)
    );

    always_comb begin
        w_in1 = '0;
        w_in2 = '0;
        case (w_op)
            c_op_rtype, c_op_bne, c_op_beq, c_op_bgz, c_op_blz: begin
                w_in1 = rf_data1;
                w_in2 = rf_data2;
            end
            c_op_adi, c_op_ori, c_op_lwd, c_op_swd: begin
                w_in1 = rf_data1;
                w_in2 = w_imm;
            end
            c_op_lhi, c_op_jmp, c_op_jal: begin
                w_in2 = w_imm;
            end
            default: begin
                w_in1 = '0;
                w_in2 = '0;
            end
        endcase
    end

    // JPR/JRL and unknown functs fall through to NONE with dest 0
    always_comb begin
        w_kind = KIND_NONE;
        w_dest = '0;
        case (w_op)
            c_op_rtype: begin
                if (w_funct < c_funct_wb_limit) begin
                    w_kind = KIND_WB;
                    w_dest = RADDR_W'(r_instr[c_rd_msb:c_rd_lsb]);
                end
            end
            c_op_adi, c_op_ori, c_op_lhi: begin
                w_kind = KIND_WB;
                w_dest = RADDR_W'(r_instr[c_rt_msb:c_rt_lsb]);
            end
            c_op_lwd, c_op_swd:                     w_kind = KIND_MEM;
            c_op_bne, c_op_beq, c_op_bgz, c_op_blz: w_kind = KIND_BRANCH;
            c_op_jmp, c_op_jal:                     w_kind = KIND_JUMP;
            default:                                w_kind = KIND_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_arm_cnt      <= '0;
            r_instr        <= '0;
            r_instr_ready  <= 1'b1;
            r_rf_addr1     <= '0;
            r_rf_addr2     <= '0;
            r_alu_input_1  <= '0;
            r_alu_input_2  <= '0;
            r_alu_instr    <= '0;
            r_input_ready  <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_kind  <= KIND_NONE;
            r_result_data  <= '0;
            r_result_dest  <= '0;
            r_result_taken <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr       <= instruction;
                        r_rf_addr1    <= RADDR_W'(instruction[c_rs_msb:c_rs_lsb]);
                        r_rf_addr2    <= RADDR_W'(instruction[c_rt_msb:c_rt_lsb]);
                        r_instr_ready <= 1'b0;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    r_alu_input_1 <= w_in1;
                    r_alu_input_2 <= w_in2;
                    r_alu_instr   <= r_instr;
                    r_input_ready <= 1'b1;
                    r_arm_cnt     <= '0;
                    r_state       <= S_ARM;
                end
                S_ARM: begin
                    // Operands are already stable; the drop of input_ready is the ALU trigger
                    if (r_arm_cnt == c_cnt_w'(ARM_CYCLES - 1)) begin
                        r_input_ready <= 1'b0;
                        r_state       <= S_FIRE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                S_FIRE: begin
                    r_result_valid <= 1'b1;
                    r_result_kind  <= w_kind;
                    r_result_data  <= alu_output;
                    r_result_dest  <= w_dest;
                    r_result_taken <= (w_kind == KIND_BRANCH) ? branch_bit : 1'b0;
                    r_state        <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_instr_ready <= 1'b1;
                    r_input_ready <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = r_instr_ready;
    assign rf_addr1     = r_rf_addr1;
    assign rf_addr2     = r_rf_addr2;
    assign alu_input_1  = r_alu_input_1;
    assign alu_input_2  = r_alu_input_2;
    assign alu_instr    = r_alu_instr;
    assign input_ready  = r_input_ready;
    assign result_valid = r_result_valid;
    assign result_kind  = r_result_kind;
    assign result_data  = r_result_data;
    assign result_dest  = r_result_dest;
    assign result_taken = r_result_taken;

endmodule

`default_nettype wire
